eu_issue_tx_way0: RTL and testbench

Issue-side transmitter for way 0: accepts decoded, operand-read instruction packets from the decode/regfile stage and pushes them into the way-0 execute-unit input buffer. The execute-unit buffer exposes no full flag, so this block tracks buffer occupancy locally and never asserts a write when the buffer is full. On a jump it discards everything in flight on both sides in lockstep with the buffer's own flush.

---
 rtl/b8_issue_pkg.sv | 22 ++
 rtl/issue_skid_fifo.sv | 52 +++++
 rtl/eu_issue_tx_way0.sv | 72 +++++++
 tb/tb_eu_issue_tx_way0.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/b8_issue_pkg.sv
// Shared types for the way-0 issue transmitter.
//   issue_pkt_t  : decoded, operand-read instruction packet (255 bits)
//   EU_DEPTH_DEF : default entry count of the downstream EU input buffer
package b8_issue_pkg;

  localparam int EU_DEPTH_DEF = 4;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic        rd_write_enable;
    logic [31:0] inst_addr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm;
    logic [6:0]  op_code;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [5:0]  shamt;
    logic [1:0]  pid;
  } issue_pkt_t;

endpackage

// File: rtl/issue_skid_fifo.sv
// Small synchronous FIFO of issue packets used as the skid queue.
//   push/pop : write/read strobes; a push while full is taken only if a pop
//              happens in the same cycle
//   flush    : empties the queue on the next edge (wins over push/pop)
//   full/empty/head : status from registered pointers, head = oldest entry
module issue_skid_fifo
  import b8_issue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  issue_pkt_t din,
  output logic       full,
  output logic       empty,
  output issue_pkt_t head
);

  localparam int AW = $clog2(DEPTH);

  issue_pkt_t    mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          do_push, do_pop;

  // Extra pointer bit distinguishes full from empty across wrap.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/eu_issue_tx_way0.sv
// Way-0 issue transmitter. Buffers upstream packets in a skid queue and
// writes them into the EU input buffer, tracking that buffer's occupancy
// locally since it exposes no full flag.
//   pkt_i/pktValid_i/pktReady_o : upstream valid/ready handshake
//   pkt_o/euValid_o             : EU buffer write data / write strobe
//   euReady_i                   : EU buffer read enable (consumes one credit)
//   jumpFlag_i                  : flush, shared with the EU buffer
//   occupancy_o                 : tracked EU buffer occupancy
module eu_issue_tx_way0
  import b8_issue_pkg::*;
#(
  parameter int EU_DEPTH   = EU_DEPTH_DEF,
  parameter int SKID_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  issue_pkt_t                    pkt_i,
  input  logic                          pktValid_i,
  output logic                          pktReady_o,
  output issue_pkt_t                    pkt_o,
  output logic                          euValid_o,
  input  logic                          euReady_i,
  input  logic                          jumpFlag_i,
  output logic [$clog2(EU_DEPTH+1)-1:0] occupancy_o
);

  localparam int OW = $clog2(EU_DEPTH+1);

  logic [OW-1:0] occ;
  logic [OW:0]   occ_sum;
  logic          skid_full, skid_empty;
  logic          send, consume, accept;

  assign consume    = euReady_i && (occ != '0);
  // A full buffer still takes a write in a cycle where it is also read.
  assign send       = !skid_empty && ((occ < OW'(EU_DEPTH)) || consume) && !jumpFlag_i;
  assign pktReady_o = !skid_full;
  assign accept     = pktValid_i && !skid_full && !jumpFlag_i;
  assign euValid_o  = send;
  assign occupancy_o = occ;

  // One bit wider so both overflow and underflow would show up as > EU_DEPTH.
  assign occ_sum = {1'b0, occ} + (OW+1)'(send) - (OW+1)'(consume);

  issue_skid_fifo #(.DEPTH(SKID_DEPTH)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .pop     (send),
    .flush   (jumpFlag_i),
    .din     (pkt_i),
    .full    (skid_full),
    .empty   (skid_empty),
    .head    (pkt_o)
  );

  // Jump clears the count in lockstep with the EU buffer flush; any read in
  // the jump cycle is moot because the buffer is emptied anyway.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        occ <= '0;
    else if (jumpFlag_i) occ <= '0;
    else                 occ <= occ_sum[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset_n && !jumpFlag_i) begin
      assert (occ_sum <= (OW+1)'(EU_DEPTH))
        else $error("occupancy out of range: %0d", occ_sum);
    end
  end

endmodule

// File: tb/tb_eu_issue_tx_way0.sv
module tb_eu_issue_tx_way0;
  import b8_issue_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  issue_pkt_t pkt_i;
  logic       pktValid_i;
  logic       pktReady_o;
  issue_pkt_t pkt_o;
  logic       euValid_o;
  logic       euReady_i;
  logic       jumpFlag_i;
  logic [2:0] occupancy_o;

  int tests = 0;
  int fails = 0;
  int k, sent;
  logic acc;

  always #5 clk = ~clk;

  eu_issue_tx_way0 #(.EU_DEPTH(4), .SKID_DEPTH(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pkt_i       (pkt_i),
    .pktValid_i  (pktValid_i),
    .pktReady_o  (pktReady_o),
    .pkt_o       (pkt_o),
    .euValid_o   (euValid_o),
    .euReady_i   (euReady_i),
    .jumpFlag_i  (jumpFlag_i),
    .occupancy_o (occupancy_o)
  );

  function automatic issue_pkt_t mk(input int n);
    issue_pkt_t p;
    p.rd_addr         = 5'(n + 1);
    p.rd_write_enable = n[0];
    p.inst_addr       = 32'h8000_0000 + 32'(n * 4);
    p.rs1_data        = 64'h1111_0000_0000_0000 | 64'(n);
    p.rs2_data        = 64'h2222_0000_0000_0000 | 64'(n);
    p.imm             = 64'hFFFF_FFFF_0000_0000 | 64'(n * 3);
    p.op_code         = 7'(19 + n);
    p.funct3          = 3'(n);
    p.funct7          = 7'(n * 5);
    p.shamt           = 6'(n);
    p.pid             = 2'(n);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [254:0] obs, input logic [254:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    pktValid_i = 1'b0;
    euReady_i  = 1'b0;
    jumpFlag_i = 1'b0;
    pkt_i      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  initial begin
    // ---- reset state
    do_reset();
    #1;
    chk("rst_valid", euValid_o, 0);
    chk("rst_ready", pktReady_o, 1);
    chk("rst_occ", occupancy_o, 0);
    chk("rst_pkt", pkt_o, 0);

    // ---- single packet, 1-cycle latency
    pktValid_i = 1; pkt_i = mk(0);
    #1;
    chk("t1_c0_valid", euValid_o, 0);
    chk("t1_c0_ready", pktReady_o, 1);
    edge1();
    pktValid_i = 0; pkt_i = '0;
    #1;
    chk("t1_c1_valid", euValid_o, 1);
    chk("t1_c1_pkt", pkt_o, mk(0));
    chk("t1_c1_addr", pkt_o.inst_addr, 32'h8000_0000);
    chk("t1_c1_op", pkt_o.op_code, 7'h13);
    edge1();
    #1;
    chk("t1_c2_occ", occupancy_o, 1);
    chk("t1_c2_valid", euValid_o, 0);

    // ---- no reads, 6 packets offered: 4 writes, skid fills
    do_reset();
    k = 0; sent = 0;
    for (int c = 0; c < 10; c++) begin
      pktValid_i = (k < 6); pkt_i = mk(10 + k); euReady_i = 0;
      #1;
      if (euValid_o) begin
        chk("t2_order", pkt_o, mk(10 + sent));
        sent++;
      end
      chk("t2_no_wr_full", euValid_o && (occupancy_o == 3'd4), 0);
      acc = pktValid_i && pktReady_o;
      edge1();
      if (acc) k++;
    end
    pktValid_i = 0;
    #1;
    chk("t2_sends", sent, 4);
    chk("t2_occ", occupancy_o, 4);
    chk("t2_ready", pktReady_o, 0);
    chk("t2_accepted", k, 6);

    // ---- full buffer, single read: write in same cycle, occ holds
    euReady_i = 1;
    #1;
    chk("t3_valid", euValid_o, 1);
    chk("t3_pkt", pkt_o, mk(14));
    edge1();
    euReady_i = 0;
    #1;
    chk("t3_occ", occupancy_o, 4);
    chk("t3_valid_after", euValid_o, 0);
    chk("t3_ready", pktReady_o, 1);
    chk("t3_head", pkt_o, mk(15));

    // ---- refill skid, then jump with buffer full and skid full
    pktValid_i = 1; pkt_i = mk(16);
    edge1();
    pktValid_i = 0;
    #1;
    chk("t4_pre_ready", pktReady_o, 0);
    chk("t4_pre_occ", occupancy_o, 4);
    jumpFlag_i = 1; euReady_i = 1; pktValid_i = 1; pkt_i = mk(17);
    #1;
    chk("t4_jump_valid", euValid_o, 0);
    edge1();
    jumpFlag_i = 0; euReady_i = 0; pktValid_i = 0;
    #1;
    chk("t4_occ", occupancy_o, 0);
    chk("t4_empty", euValid_o, 0);
    chk("t4_ready", pktReady_o, 1);
    pktValid_i = 1; pkt_i = mk(18);
    edge1();
    pktValid_i = 0;
    #1;
    chk("t4_next_valid", euValid_o, 1);
    chk("t4_next_pkt", pkt_o, mk(18));
    edge1();
    #1;
    chk("t4_next_occ", occupancy_o, 1);

    // ---- streaming 16 packets with continuous read
    do_reset();
    k = 0; sent = 0;
    for (int c = 0; c < 19; c++) begin
      pktValid_i = (k < 16); pkt_i = mk(40 + k); euReady_i = 1;
      #1;
      if (c >= 1 && c <= 16) chk("t5_rate", euValid_o, 1);
      if (euValid_o) begin
        chk("t5_order", pkt_o, mk(40 + sent));
        sent++;
      end
      chk("t5_occ_bound", occupancy_o <= 3'd1, 1);
      acc = pktValid_i && pktReady_o;
      edge1();
      if (acc) k++;
    end
    chk("t5_sent", sent, 16);
    chk("t5_accepted", k, 16);

    // ---- async reset mid-stream
    euReady_i = 0;
    for (int c = 0; c < 3; c++) begin
      pktValid_i = 1; pkt_i = mk(70 + c);
      edge1();
    end
    #1;
    chk("t6_pre_valid", euValid_o, 1);
    #2 reset_n = 0;
    #1;
    chk("t6_rst_valid", euValid_o, 0);
    chk("t6_rst_ready", pktReady_o, 1);
    chk("t6_rst_occ", occupancy_o, 0);
    chk("t6_rst_pkt", pkt_o, 0);
    euReady_i = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_hold_valid", euValid_o, 0);
    pktValid_i = 0;
    @(negedge clk) reset_n = 1;
    for (int c = 0; c < 3; c++) begin
      edge1();
      #1;
      chk("t6_post_valid", euValid_o, 0);
      chk("t6_post_occ", occupancy_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
